// File: rtl/adc_frame_capture_ctrl.sv
// ADC frame capture sequencer: hunts for start-of-frame, fills a shadow buffer and
// commits it atomically to a held output frame with a valid/ack handshake.
module adc_frame_capture_ctrl #(
  parameter int WORDS_PER_FRAME = 10,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_word,
  input  logic                         in_sof,
  output logic [32*WORDS_PER_FRAME-1:0] frame_words_packed,
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic [CNT_W-1:0]             frame_seq,
  output logic [CNT_W-1:0]             overrun_cnt,
  output logic [CNT_W-1:0]             resync_cnt,
  output logic                         busy
);

  localparam int IDX_W = $clog2(WORDS_PER_FRAME);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [31:0]       shadow_r [WORDS_PER_FRAME];
  logic              busy_r;
  logic              accept_s;

  // Stream handshake decoded straight from the state register.
  assign in_ready = (state_r == HUNT) || (state_r == FILL);
  assign accept_s = in_valid & in_ready;
  assign busy     = busy_r;

  // Capture FSM with shadow buffer, committed frame and status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      idx_r              <= {IDX_W{1'b0}};
      busy_r             <= 1'b0;
      frame_words_packed <= {(32*WORDS_PER_FRAME){1'b0}};
      frame_valid        <= 1'b0;
      frame_seq          <= {CNT_W{1'b0}};
      overrun_cnt        <= {CNT_W{1'b0}};
      resync_cnt         <= {CNT_W{1'b0}};
      for (int k = 0; k < WORDS_PER_FRAME; k++) begin
        shadow_r[k] <= 32'h0000_0000;
      end
    end else begin
      // An ack retires a pending frame unless a commit load below overrides it.
      if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
      end

      if (!enable) begin
        state_r <= IDLE;
        idx_r   <= {IDX_W{1'b0}};
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= HUNT;
            busy_r  <= 1'b0;
          end
          HUNT: begin
            if (accept_s && in_sof) begin
              shadow_r[0] <= in_word;
              idx_r       <= IDX_W'(1);
              state_r     <= FILL;
              busy_r      <= 1'b1;
            end
          end
          FILL: begin
            if (accept_s) begin
              if (in_sof) begin
                if (resync_cnt != {CNT_W{1'b1}}) begin
                  resync_cnt <= resync_cnt + CNT_W'(1);
                end
                shadow_r[0] <= in_word;
                idx_r       <= IDX_W'(1);
              end else begin
                shadow_r[idx_r] <= in_word;
                if (idx_r == IDX_W'(WORDS_PER_FRAME - 1)) begin
                  idx_r   <= {IDX_W{1'b0}};
                  state_r <= COMMIT;
                end else begin
                  idx_r <= idx_r + IDX_W'(1);
                end
              end
            end
          end
          COMMIT: begin
            state_r <= HUNT;
            busy_r  <= 1'b0;
            // A still-pending, unacked frame wins; the new one is dropped.
            if (frame_valid && !frame_ack) begin
              if (overrun_cnt != {CNT_W{1'b1}}) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
              end
            end else begin
              for (int k = 0; k < WORDS_PER_FRAME; k++) begin
                frame_words_packed[32*k +: 32] <= shadow_r[k];
              end
              frame_valid <= 1'b1;
              frame_seq   <= frame_seq + CNT_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_capture_ctrl.sv
// Directed self-checking bench for adc_frame_capture_ctrl.
module tb_adc_frame_capture_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         in_sof;
  logic [319:0] frame_words_packed;
  logic         frame_valid;
  logic         frame_ack;
  logic [15:0]  frame_seq;
  logic [15:0]  overrun_cnt;
  logic [15:0]  resync_cnt;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] f1 [10] = '{32'hA5A55A5A, 32'h00000001, 32'h00007FFF, 32'h00008000,
                           32'h0000FFFF, 32'h00800000, 32'h00FFFFFF, 32'h00900000,
                           32'h00000000, 32'hDEADBEEF};

  always #5 clk = ~clk;

  adc_frame_capture_ctrl #(.WORDS_PER_FRAME(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_sof(in_sof), .frame_words_packed(frame_words_packed),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_seq(frame_seq),
    .overrun_cnt(overrun_cnt), .resync_cnt(resync_cnt), .busy(busy)
  );

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] exp_frame(input logic [31:0] salt);
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = f1[k] + salt;
    return r;
  endfunction

  task automatic send(input logic [31:0] w, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_word = w; in_sof = s;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 320'(in_ready), 320'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] salt);
    for (int k = 0; k < 10; k++) send(f1[k] + salt, (k == 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; frame_ack = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_word = 32'h0; in_sof = 1'b0;
    frame_ack = 1'b0;
    step();
    check("rst_valid", 320'(frame_valid), 320'(1'b0));
    check("rst_packed", frame_words_packed, 320'h0);
    check("rst_seq", 320'(frame_seq), 320'(16'd0));
    check("rst_ovr", 320'(overrun_cnt), 320'(16'd0));
    check("rst_resync", 320'(resync_cnt), 320'(16'd0));
    check("rst_ready", 320'(in_ready), 320'(1'b0));
    check("rst_busy", 320'(busy), 320'(1'b0));

    // Test 1: basic frame capture and commit latency
    do_reset();
    send_frame(32'h0);
    check("t1_commit_ready", 320'(in_ready), 320'(1'b0));
    check("t1_commit_busy", 320'(busy), 320'(1'b1));
    check("t1_pre_valid", 320'(frame_valid), 320'(1'b0));
    step();
    check("t1_valid", 320'(frame_valid), 320'(1'b1));
    check("t1_ready_back", 320'(in_ready), 320'(1'b1));
    check("t1_word0", 320'(frame_words_packed[31:0]), 320'(32'hA5A55A5A));
    check("t1_word9", 320'(frame_words_packed[319:288]), 320'(32'hDEADBEEF));
    check("t1_packed", frame_words_packed, exp_frame(32'h0));
    check("t1_seq", 320'(frame_seq), 320'(16'd1));
    pulse_ack();
    check("t1_ack_clear", 320'(frame_valid), 320'(1'b0));

    // Test 2: leading non-SOF words are discarded
    do_reset();
    send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0);
    send_frame(32'h0);
    step();
    check("t2_packed", frame_words_packed, exp_frame(32'h0));
    check("t2_seq", 320'(frame_seq), 320'(16'd1));
    check("t2_resync", 320'(resync_cnt), 320'(16'd0));

    // Test 3: SOF as 5th word restarts the frame
    do_reset();
    send(32'h5555_0000, 1'b1);
    send(32'h5555_0001, 1'b0); send(32'h5555_0002, 1'b0); send(32'h5555_0003, 1'b0);
    send_frame(32'h2);
    step();
    check("t3_resync", 320'(resync_cnt), 320'(16'd1));
    check("t3_packed", frame_words_packed, exp_frame(32'h2));
    check("t3_seq", 320'(frame_seq), 320'(16'd1));

    // Test 4: overrun on unacked frame, then recovery
    do_reset();
    send_frame(32'h0);
    step();
    send_frame(32'h3);
    step();
    check("t4_ovr", 320'(overrun_cnt), 320'(16'd1));
    check("t4_packed_kept", frame_words_packed, exp_frame(32'h0));
    check("t4_seq", 320'(frame_seq), 320'(16'd1));
    check("t4_valid", 320'(frame_valid), 320'(1'b1));
    pulse_ack();
    check("t4_ack_clear", 320'(frame_valid), 320'(1'b0));
    send_frame(32'h4);
    step();
    check("t4_seq2", 320'(frame_seq), 320'(16'd2));
    check("t4_packed3", frame_words_packed, exp_frame(32'h4));

    // Test 5: ack in the COMMIT cycle; load wins
    do_reset();
    send_frame(32'h0);
    step();
    send_frame(32'h5);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("t5_valid", 320'(frame_valid), 320'(1'b1));
    check("t5_packed", frame_words_packed, exp_frame(32'h5));
    check("t5_ovr", 320'(overrun_cnt), 320'(16'd0));
    check("t5_seq", 320'(frame_seq), 320'(16'd2));

    // Test 6: disable mid-fill, re-enable, then async reset mid-fill
    send(32'h6666_0000, 1'b1);
    send(32'h6666_0001, 1'b0); send(32'h6666_0002, 1'b0); send(32'h6666_0003, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    step();
    check("t6_idle_ready", 320'(in_ready), 320'(1'b0));
    check("t6_idle_busy", 320'(busy), 320'(1'b0));
    check("t6_valid_kept", 320'(frame_valid), 320'(1'b1));
    check("t6_packed_kept", frame_words_packed, exp_frame(32'h5));
    pulse_ack();
    @(negedge clk);
    enable = 1'b1;
    send_frame(32'h7);
    step();
    check("t6_packed_new", frame_words_packed, exp_frame(32'h7));
    check("t6_seq", 320'(frame_seq), 320'(16'd3));
    check("t6_ovr", 320'(overrun_cnt), 320'(16'd0));
    check("t6_resync", 320'(resync_cnt), 320'(16'd0));
    send(32'h7777_0000, 1'b1); send(32'h7777_0001, 1'b0); send(32'h7777_0002, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_packed", frame_words_packed, 320'h0);
    check("t6_rst_valid", 320'(frame_valid), 320'(1'b0));
    check("t6_rst_seq", 320'(frame_seq), 320'(16'd0));
    check("t6_rst_busy", 320'(busy), 320'(1'b0));
    check("t6_rst_ready", 320'(in_ready), 320'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
